// File: rtl/mem_mp_rv.sv
`default_nettype none
// ============================================================================
// Module   : mem_mp_rv
// Brief    : Multi-port register-file memory with valid bits, write priority,
//            optional bypass / registered read and a post-reset clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module mem_mp_rv #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 32,
  parameter int READ_PORTS   = 2,
  parameter int WRITE_PORTS  = 2,
  parameter int BYPASS_EN    = 0,
  parameter int READ_LATENCY = 0,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 flush,
  output logic                                 busy,
  input  logic [READ_PORTS-1:0]                re,
  input  logic [READ_PORTS-1:0][AW-1:0]        raddr,
  output logic [READ_PORTS-1:0][WIDTH-1:0]     rdata,
  output logic [READ_PORTS-1:0]                rvalid,
  input  logic [WRITE_PORTS-1:0]               we,
  input  logic [WRITE_PORTS-1:0][AW-1:0]       waddr,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]    wdata,
  output logic                                 wr_conflict
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [AW-1:0]                        r_sidx;
  logic [AW-1:0]                        w_sidx_nxt;
  logic [WIDTH-1:0]                     r_mem [DEPTH];
  logic [DEPTH-1:0]                     r_vbit;
  logic                                 w_wr_ok;
  logic [WRITE_PORTS-1:0]               w_win;
  logic [WRITE_PORTS-1:0]               w_wen;
  logic                                 w_conf;
  logic [READ_PORTS-1:0][WIDTH-1:0]     w_rd_data;
  logic [READ_PORTS-1:0]                w_rd_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_SWEEP;
      r_sidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sidx  <= w_sidx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sidx_nxt  = r_sidx;
    if (flush) begin
      w_state_nxt = ST_SWEEP;
      w_sidx_nxt  = '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          if (r_sidx == c_last) begin
            w_state_nxt = ST_IDLE;
            w_sidx_nxt  = '0;
          end else begin
            w_sidx_nxt = r_sidx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == ST_SWEEP);
  assign w_wr_ok = !busy && !flush;

  // Out-of-range write ports are dropped entirely, including from conflict detection.
  always_comb begin
    w_win = '0;
    w_wen = '0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      w_win[j] = (32'(waddr[j]) < DEPTH);
      w_wen[j] = we[j] && w_win[j] && w_wr_ok;
    end
  end

  always_comb begin
    w_conf = 1'b0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      for (int k = j + 1; k < WRITE_PORTS; k++) begin
        if (w_wen[j] && w_wen[k] && (waddr[j] == waddr[k])) w_conf = 1'b1;
      end
    end
  end

  assign wr_conflict = w_conf;

  // Ascending port order lets the highest-index writer land last.
  always_ff @(posedge clock) begin
    if (busy) begin
      r_mem[r_sidx] <= '0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (w_wen[j]) r_mem[waddr[j]] <= wdata[j];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vbit <= '0;
    end else if (flush) begin
      r_vbit <= '0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (w_wen[j]) r_vbit[waddr[j]] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (re[i] && !busy && (32'(raddr[i]) < DEPTH)) begin
        w_rd_data[i]  = r_mem[raddr[i]];
        w_rd_valid[i] = r_vbit[raddr[i]];
        if (BYPASS_EN != 0) begin
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (w_wen[j] && (waddr[j] == raddr[i])) begin
              w_rd_data[i]  = wdata[j];
              w_rd_valid[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_rd_comb
      assign rdata  = w_rd_data;
      assign rvalid = w_rd_valid;
    end else begin : g_rd_reg
      logic [READ_PORTS-1:0][WIDTH-1:0] r_rdata;
      logic [READ_PORTS-1:0]            r_rvalid;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_rdata  <= '0;
          r_rvalid <= '0;
        end else begin
          r_rdata  <= w_rd_data;
          r_rvalid <= w_rd_valid;
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_mp_rv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_mp_rv
// Brief    : Directed self-checking bench for mem_mp_rv in four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_mp_rv;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  flush;
  logic [1:0]            re;
  logic [1:0][4:0]       raddr;
  logic [1:0]            we;
  logic [1:0][4:0]       waddr;
  logic [1:0][63:0]      wdata;

  logic                  busy_b, busy_y, busy_l, busy_d;
  logic [1:0][63:0]      rd_b, rd_y, rd_l, rd_d;
  logic [1:0]            rv_b, rv_y, rv_l, rv_d;
  logic                  cf_b, cf_y, cf_l, cf_d;

  int n_checks = 0;
  int n_errors = 0;
  int c_b;
  int c_d;

  always #5 clock = ~clock;

  mem_mp_rv u_base (
    .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_b),
    .re(re), .raddr(raddr), .rdata(rd_b), .rvalid(rv_b),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_conflict(cf_b)
  );

  mem_mp_rv #(.BYPASS_EN(1)) u_byp (
    .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_y),
    .re(re), .raddr(raddr), .rdata(rd_y), .rvalid(rv_y),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_conflict(cf_y)
  );

  mem_mp_rv #(.READ_LATENCY(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_l),
    .re(re), .raddr(raddr), .rdata(rd_l), .rvalid(rv_l),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_conflict(cf_l)
  );

  mem_mp_rv #(.DEPTH(20)) u_d20 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_d),
    .re(re), .raddr(raddr), .rdata(rd_d), .rvalid(rv_d),
    .we(we), .waddr(waddr), .wdata(wdata), .wr_conflict(cf_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    #12;
    chk("rst_busy", 64'(busy_b), 64'd1);
    chk("rst_l1_rdata", rd_l[0], 64'd0);
    chk("rst_l1_rvalid", 64'(rv_l), 64'd0);

    @(posedge clock); #1;
    reset_n = 1'b1;
    c_b = 0; c_d = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy_b && c_b == 0) c_b = i;
      if (!busy_d && c_d == 0) c_d = i;
    end
    chk("sweep_edges_32", 64'(c_b), 64'd32);
    chk("sweep_edges_20", 64'(c_d), 64'd20);

    re = 2'b01; raddr[0] = 5'd5; #4;
    chk("post_sweep_rdata", rd_b[0], 64'd0);
    chk("post_sweep_rvalid", 64'(rv_b[0]), 64'd0);

    tick(); re = '0; we = 2'b01; waddr[0] = 5'd3; wdata[0] = 64'hA5; #4;
    chk("single_wr_noconf", 64'(cf_b), 64'd0);

    tick(); we = '0; re = 2'b10; raddr[1] = 5'd3; #4;
    chk("rd3_data", rd_b[1], 64'hA5);
    chk("rd3_valid", 64'(rv_b[1]), 64'd1);

    tick(); re = '0; we = 2'b01; waddr[0] = 5'd4; wdata[0] = 64'hFF;
    tick(); we = '0; re = 2'b01; raddr[0] = 5'd4;
    tick(); re = '0;
    chk("lat1_data", rd_l[0], 64'hFF);
    chk("lat1_valid", 64'(rv_l[0]), 64'd1);
    tick();
    chk("lat1_idle_data", rd_l[0], 64'd0);
    chk("lat1_idle_valid", 64'(rv_l[0]), 64'd0);

    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 64'd1; wdata[1] = 64'd2; #4;
    chk("conflict_7", 64'(cf_b), 64'd1);

    tick(); waddr[0] = 5'd25; waddr[1] = 5'd25; wdata[0] = 64'h11; wdata[1] = 64'h22; #4;
    chk("conflict_oor_d20", 64'(cf_d), 64'd0);
    chk("conflict_25_d32", 64'(cf_b), 64'd1);

    tick(); we = '0; re = 2'b11; raddr[0] = 5'd7; raddr[1] = 5'd25; #4;
    chk("prio_rd7", rd_b[0], 64'd2);
    chk("prio_rd25_d32", rd_b[1], 64'h22);
    chk("prio_rv25_d32", 64'(rv_b[1]), 64'd1);
    chk("oor_rd_d20", rd_d[1], 64'd0);
    chk("oor_rv_d20", 64'(rv_d[1]), 64'd0);

    tick(); re = '0; we = 2'b01; waddr[0] = 5'd9; wdata[0] = 64'h33;
    tick();
    we = 2'b11; waddr[0] = 5'd9; wdata[0] = 64'h55; waddr[1] = 5'd10; wdata[1] = 64'h66;
    re = 2'b11; raddr[0] = 5'd9; raddr[1] = 5'd10; #4;
    chk("byp_rd9", rd_y[0], 64'h55);
    chk("byp_rv9", 64'(rv_y[0]), 64'd1);
    chk("nobyp_rd9", rd_b[0], 64'h33);
    chk("nobyp_rv9", 64'(rv_b[0]), 64'd1);
    chk("byp_rd10", rd_y[1], 64'h66);
    chk("nobyp_rd10", rd_b[1], 64'd0);
    chk("nobyp_rv10", 64'(rv_b[1]), 64'd0);

    tick();
    flush = 1'b1; we = 2'b11; waddr[0] = 5'd12; waddr[1] = 5'd12;
    wdata[0] = 64'h77; wdata[1] = 64'h88; re = 2'b01; raddr[0] = 5'd3; #4;
    chk("flush_conf_supp", 64'(cf_b), 64'd0);
    chk("flush_cycle_rd", rd_b[0], 64'hA5);
    chk("flush_cycle_rv", 64'(rv_b[0]), 64'd1);

    tick(); flush = 1'b0; we = '0; re = '0;
    chk("flush_busy", 64'(busy_b), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1; re = 2'b01; raddr[0] = 5'd3; #4;
    chk("midsweep_rd", rd_b[0], 64'd0);
    chk("midsweep_rv", 64'(rv_b[0]), 64'd0);

    c_b = 0; c_d = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) flush = 1'b0;
      if (!busy_b && c_b == 0) c_b = i;
      if (!busy_d && c_d == 0) c_d = i;
    end
    chk("reflush_len32", 64'(c_b), 64'd33);
    chk("reflush_len20", 64'(c_d), 64'd21);

    re = 2'b11; raddr[0] = 5'd3; raddr[1] = 5'd7; #4;
    chk("post_flush_rv", 64'(rv_b), 64'd0);
    chk("post_flush_rd3", rd_b[0], 64'd0);
    chk("post_flush_byp_rv", 64'(rv_y), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
